// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC sequencing with stall/redirect, byte-loadable
// instruction memory with asynchronous word read, and a sticky fault state.
module instruction_fetch #(
  parameter int unsigned IMEM_BYTES = 64,
  parameter logic [63:0] RESET_PC   = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  input  logic        imem_we,
  input  logic [63:0] imem_addr,
  input  logic [7:0]  imem_wdata,
  output logic [31:0] Instruction,
  output logic [63:0] PC_Out,
  output logic        fetch_valid,
  output logic        fault
);

  localparam int unsigned AW        = $clog2(IMEM_BYTES);
  localparam logic [63:0] MEM_SIZE  = 64'(IMEM_BYTES);
  localparam logic [63:0] LAST_WORD = 64'(IMEM_BYTES - 4);
  localparam logic [31:0] NOP       = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [63:0]     pc;
  logic [63:0]     pc_nxt;
  logic            bubble;
  logic            bubble_nxt;
  logic [7:0]      mem [IMEM_BYTES];
  logic            pc_ok;
  logic [AW-1:0]   rd_idx;
  logic [31:0]     rd_word;

  // A fetch is legal only for a word-aligned PC whose whole word lies in memory.
  assign pc_ok = (pc[1:0] == 2'b00) && (pc <= LAST_WORD);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= BOOT;
      pc     <= RESET_PC;
      bubble <= 1'b0;
    end else begin
      state  <= state_nxt;
      pc     <= pc_nxt;
      bubble <= bubble_nxt;
    end
  end

  // Redirect beats stall; a redirect always leaves a one-cycle bubble behind it.
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    bubble_nxt = 1'b0;
    case (state)
      BOOT: begin
        state_nxt = RUN;
      end
      RUN: begin
        if (branch_taken) begin
          pc_nxt     = branch_target;
          bubble_nxt = 1'b1;
        end else if (stall) begin
          pc_nxt = pc;
        end else if (!pc_ok) begin
          state_nxt = FAULT;
        end else begin
          pc_nxt = pc + 64'd4;
        end
      end
      FAULT: begin
        state_nxt = FAULT;
      end
      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

  // Memory is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (imem_we && (imem_addr < MEM_SIZE)) begin
      mem[imem_addr[AW-1:0]] <= imem_wdata;
    end
  end

  always_comb begin
    rd_idx  = pc_ok ? pc[AW-1:0] : '0;
    rd_word = {mem[AW'(rd_idx + AW'(3))], mem[AW'(rd_idx + AW'(2))],
               mem[AW'(rd_idx + AW'(1))], mem[rd_idx]};
  end

  always_comb begin
    PC_Out      = pc;
    Instruction = NOP;
    fetch_valid = 1'b0;
    fault       = 1'b0;
    case (state)
      RUN: begin
        Instruction = pc_ok ? rd_word : NOP;
        fetch_valid = !bubble;
      end
      FAULT: begin
        fault = 1'b1;
      end
      default: begin
        fault = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table, hand-written reset and
// end-of-memory sequences, then random traffic against a reference model.
module tb_instruction_fetch;

  localparam int unsigned IMEM_BYTES = 64;
  localparam logic [63:0] RESET_PC   = 64'h0;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        branch_taken;
  logic [63:0] branch_target;
  logic        imem_we;
  logic [63:0] imem_addr;
  logic [7:0]  imem_wdata;
  logic [31:0] Instruction;
  logic [63:0] PC_Out;
  logic        fetch_valid;
  logic        fault;

  instruction_fetch #(.IMEM_BYTES(IMEM_BYTES), .RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem_we       (imem_we),
    .imem_addr     (imem_addr),
    .imem_wdata    (imem_wdata),
    .Instruction   (Instruction),
    .PC_Out        (PC_Out),
    .fetch_valid   (fetch_valid),
    .fault         (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: the three named modes plus PC, pending-bubble flag and memory image.
  localparam int M_BOOT  = 0;
  localparam int M_RUN   = 1;
  localparam int M_FAULT = 2;
  logic [7:0]  m_mem [IMEM_BYTES];
  int          m_mode;
  logic [63:0] m_pc;
  bit          m_bubble;

  typedef struct {
    string       name;
    logic        stall;
    logic        br;
    logic [63:0] tgt;
    logic        we;
    logic [63:0] addr;
    logic [7:0]  wd;
    logic [63:0] pc;
    logic [31:0] ins;
    logic        v;
    logic        f;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input string name, input logic st, input logic br,
                              input logic [63:0] tgt, input logic we, input logic [63:0] addr,
                              input logic [7:0] wd, input logic [63:0] pc, input logic [31:0] ins,
                              input logic v, input logic f);
    vec_t r;
    r.name = name; r.stall = st; r.br = br; r.tgt = tgt; r.we = we; r.addr = addr;
    r.wd = wd; r.pc = pc; r.ins = ins; r.v = v; r.f = f;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_const(input string tag, input logic [63:0] pc, input logic [31:0] ins,
                           input logic v, input logic f);
    chk({tag, ".pc"},    PC_Out, pc);
    chk({tag, ".instr"}, 64'(Instruction), 64'(ins));
    chk({tag, ".valid"}, 64'(fetch_valid), 64'(v));
    chk({tag, ".fault"}, 64'(fault), 64'(f));
  endtask

  function automatic logic [31:0] m_instr();
    int a;
    if (m_mode != M_RUN) return NOP;
    if (m_pc[1:0] != 2'b00) return NOP;
    if (m_pc > 64'(IMEM_BYTES - 4)) return NOP;
    a = int'(m_pc[31:0]);
    return {m_mem[a+3], m_mem[a+2], m_mem[a+1], m_mem[a]};
  endfunction

  task automatic chk_model(input string tag);
    chk_const(tag, m_pc, m_instr(), m_mode == M_RUN && !m_bubble, m_mode == M_FAULT);
  endtask

  task automatic model_reset();
    m_mode   = M_BOOT;
    m_pc     = RESET_PC;
    m_bubble = 0;
  endtask

  // Advance the model by one rising edge using the inputs currently driven.
  task automatic model_step();
    bit bad;
    if (imem_we && imem_addr < 64'(IMEM_BYTES)) m_mem[int'(imem_addr[31:0])] = imem_wdata;
    if (!reset) return;
    bad = (m_pc % 4 != 0) || (m_pc + 4 > 64'(IMEM_BYTES));
    case (m_mode)
      M_BOOT: begin m_mode = M_RUN; m_bubble = 0; end
      M_RUN: begin
        if (branch_taken) begin m_pc = branch_target; m_bubble = 1; end
        else if (stall) m_bubble = 0;
        else if (bad) begin m_mode = M_FAULT; m_bubble = 0; end
        else begin m_pc = m_pc + 64'd4; m_bubble = 0; end
      end
      default: m_bubble = 0;
    endcase
  endtask

  task automatic drive(input logic st, input logic br, input logic [63:0] tgt,
                       input logic we, input logic [63:0] addr, input logic [7:0] wd);
    stall = st; branch_taken = br; branch_target = tgt;
    imem_we = we; imem_addr = addr; imem_wdata = wd;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] init_word(input int i);
    case (i)
      0: return 32'h0050_0093;
      1: return 32'h0010_0113;
      2: return 32'h0020_81B3;
      default: return 32'hA000_0000 | 32'(i * 32'h111);
    endcase
  endfunction

  initial begin
    logic [31:0] w;
    logic [63:0] tgt;
    logic [63:0] addr;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    for (int i = 0; i < IMEM_BYTES; i++) m_mem[i] = 8'h00;

    // Load memory while held in reset.
    #1;
    for (int i = 0; i < IMEM_BYTES / 4; i++) begin
      w = init_word(i);
      for (int b = 0; b < 4; b++) begin
        drive(0, 0, 0, 1, 64'(i * 4 + b), w[b*8 +: 8]);
        tick();
      end
    end
    drive(0, 0, 0, 0, 0, 0);
    chk_const("in_reset", 64'h0, NOP, 0, 0);

    reset = 1'b1;
    #1;
    chk_const("boot", 64'h0, NOP, 0, 0);

    tbl.push_back(mk("f0",     0, 0, 0, 0, 0,             0,     0, 32'h0050_0093, 1, 0));
    tbl.push_back(mk("f4",     0, 0, 0, 0, 0,             0,     4, 32'h0010_0113, 1, 0));
    tbl.push_back(mk("stall1", 1, 0, 0, 0, 0,             0,     4, 32'h0010_0113, 1, 0));
    tbl.push_back(mk("stall2", 1, 0, 0, 0, 0,             0,     4, 32'h0010_0113, 1, 0));
    tbl.push_back(mk("stall3", 1, 0, 0, 0, 0,             0,     4, 32'h0010_0113, 1, 0));
    tbl.push_back(mk("f8",     0, 0, 0, 0, 0,             0,     8, 32'h0020_81B3, 1, 0));
    tbl.push_back(mk("br0_st", 1, 1, 0, 0, 0,             0,     0, 32'h0050_0093, 0, 0));
    tbl.push_back(mk("postbub",0, 0, 0, 0, 0,             0,     4, 32'h0010_0113, 1, 0));
    tbl.push_back(mk("br0",    0, 1, 0, 0, 0,             0,     0, 32'h0050_0093, 0, 0));
    tbl.push_back(mk("wr_b1",  1, 0, 0, 1, 1,             8'hFF, 0, 32'h0050_FF93, 1, 0));
    tbl.push_back(mk("rst_b1", 1, 0, 0, 1, 1,             8'h00, 0, 32'h0050_0093, 1, 0));
    tbl.push_back(mk("oor_wr", 1, 0, 0, 1, 64'h1_0000_0002, 8'hAB, 0, 32'h0050_0093, 1, 0));
    tbl.push_back(mk("br6",    0, 1, 6, 0, 0,             0,     6, NOP,           0, 0));
    tbl.push_back(mk("flt",    0, 0, 0, 0, 0,             0,     6, NOP,           0, 1));
    tbl.push_back(mk("flt_br", 0, 1, 0, 0, 0,             0,     6, NOP,           0, 1));
    tbl.push_back(mk("flt_st", 1, 0, 0, 0, 0,             0,     6, NOP,           0, 1));
    tbl.push_back(mk("flt_wr", 0, 0, 0, 1, 4,             8'h55, 6, NOP,           0, 1));

    foreach (tbl[i]) begin
      drive(tbl[i].stall, tbl[i].br, tbl[i].tgt, tbl[i].we, tbl[i].addr, tbl[i].wd);
      tick();
      chk_const(tbl[i].name, tbl[i].pc, tbl[i].ins, tbl[i].v, tbl[i].f);
    end
    drive(0, 0, 0, 0, 0, 0);

    // Asynchronous reset out of FAULT, then sequential walk off the end of memory.
    #2 reset = 1'b0;
    #1 chk_const("async_rst", 64'h0, NOP, 0, 0);
    model_reset();
    #1 reset = 1'b1;
    for (int k = 0; k < IMEM_BYTES / 4; k++) begin
      tick();
      chk({"seq.pc"}, PC_Out, 64'(k * 4));
      chk_model("seq");
      if (k == 1) chk("seq.w4", 64'(Instruction), 64'h0010_0155);
    end
    chk("w60", 64'(Instruction), 64'(init_word(15)));
    tick();
    chk_const("pc64", 64'd64, NOP, 1, 0);
    tick();
    chk_const("pc64_flt", 64'd64, NOP, 0, 1);
    #2 reset = 1'b0;
    #1 chk_const("rst_end", 64'h0, NOP, 0, 0);
    model_reset();
    #1 reset = 1'b1;
    tick();
    chk_const("retain0", 64'h0, 32'h0050_0093, 1, 0);
    tick();
    chk_const("retain4", 64'h4, 32'h0010_0155, 1, 0);

    // Random traffic against the model, with occasional asynchronous reset pulses.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0, 1:    tgt = 64'($urandom_range(0, 15) * 4);
        2:       tgt = 64'($urandom_range(0, 80));
        default: tgt = {$urandom, $urandom};
      endcase
      case ($urandom_range(0, 3))
        0:       addr = 64'($urandom_range(64, 70));
        1:       addr = 64'h1_0000_0000 + 64'($urandom_range(0, 63));
        default: addr = 64'($urandom_range(0, 63));
      endcase
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, tgt,
            $urandom_range(0, 4) == 0, addr, 8'($urandom));
      if ($urandom_range(0, 24) == 0) begin
        reset = 1'b0;
        #1;
        model_reset();
        chk_model("rand_rst");
        reset = 1'b1;
      end
      tick();
      chk_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
